ac_out: RTL and testbench
=========================

// Module: ac_out
// PURPOSE
//   Accumulator output port of the 8-bit processor: a load-enabled holding register.
//   - Captures the accumulator value on newData when accept is asserted.
//   - Presents the captured value on data until the next accepted load or reset.
//   - Sits between the accumulator/ALU datapath and the external output bus.
// PARAMETERS
//   WIDTH     8   data width of newData/data
//   RST_VAL   0   value loaded into data on reset
// PORTS
//   clk       in   1      system clock, rising-edge active (single clock domain)
//   rst       in   1      reset: synchronous, active-high
//   newData   in   WIDTH  candidate output value from the accumulator
//   accept    in   1      load enable, level-sensitive, sampled on rising clk
//   data      out  WIDTH  current held output value (registered)
//   valid     out  1      high once at least one load has occurred since reset
//   updated   out  1      one-cycle pulse in the cycle after a load
// BEHAVIOUR
//   - One clock (clk); reset (rst) is synchronous and active-high.
//   - All outputs are registered; there are no combinational paths from inputs to outputs.
//   - Reset (rst=1 at posedge clk):
//       data<=RST_VAL, valid<=0, updated<=0.
//       Reset dominates accept in the same cycle.
//   - Load (rst=0, accept=1 at posedge):
//       data<=newData, valid<=1, updated<=1.
//       Latency is one cycle: data reflects newData after the edge where accept was sampled.
//   - Hold (rst=0, accept=0 at posedge):
//       data and valid unchanged, updated<=0.
//       newData changes are ignored, including changes to the same value.
//   - accept held high across consecutive edges reloads newData every cycle.
//       updated stays high for each such cycle.
//   - A load of a value equal to the current data still counts as a load (updated=1).
//   - Reset in the middle of a burst of accepts clears all outputs on that edge.
//       Loading resumes on the next edge with rst=0 and accept=1.
//   - Full WIDTH-bit pass-through: no arithmetic, truncation or sign handling.
//   - X on accept while rst=0 is illegal; assertion-only, no RTL handling required.
// STRUCTURE
//   - Single flat module: one always block for the data/valid/updated flops.
//   - WIDTH and RST_VAL are local parameters; no shared package is needed.
//   - Processor-wide constants, if later shared, go in proc_pkg (DATA_W=8).
//   - No sub-module.
//       A generic enabled register (en_reg) may be reused if one already exists in the codebase.
//   - Include SystemVerilog assertions (guarded by ifdef):
//       updated implies valid.
//       data is stable when the previous-cycle accept was 0.
// TESTING
//   1. rst=1 for 2 cycles, accept=1, newData=8'hFF -> data=0, valid=0, updated=0.
//   2. Release rst, newData=1, accept=1, one edge -> data=1, valid=1, updated=1.
//   3. newData=2, accept=0 for 3 edges -> data stays 1, updated=0.
//   4. newData=4, accept=1 -> data=4; then newData=5, accept=0 -> data stays 4.
//   5. accept=1 with newData 8'hA5 then 8'h5A on back-to-back edges ->
//      data follows with 1-cycle lag, updated high on both edges.
//   6. rst=1 with accept=1, newData=8'h33 -> data=0, valid=0; release -> next load works.

Source files
------------

// File: rtl/ac_out_pkg.sv
// Shared constants for the accumulator output port.
// Widths and reset value live here so the interface and the register agree.
package ac_out_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  localparam data_t DATA_RST_VAL = '0;

endpackage : ac_out_pkg

// File: rtl/ac_out_if.sv
// Bus between the accumulator datapath (master) and the output holding register (slave).
// The master offers a candidate value on newData and qualifies it with accept.
interface ac_out_if
  import ac_out_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic [WIDTH-1:0] newData;
  logic             accept;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             updated;

  modport master (
    output newData,
    output accept,
    input  data,
    input  valid,
    input  updated
  );

  modport slave (
    input  newData,
    input  accept,
    output data,
    output valid,
    output updated
  );

endinterface : ac_out_if

// File: rtl/ac_out.sv
// Accumulator output port: a load-enabled holding register that captures newData on accept.
// valid marks that something has been loaded since reset; updated pulses for the cycle after a load.
module ac_out
  import ac_out_pkg::*;
#(
  parameter int               WIDTH   = DATA_W,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DATA_RST_VAL)
) (
  input  logic        clk,
  input  logic        rst,
  ac_out_if.slave     bus
);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic             valid_reg;
  logic             valid_next;
  logic             updated_reg;
  logic             updated_next;

  // A load of the value already held still counts as a load.
  always_comb begin
    data_next    = data_reg;
    valid_next   = valid_reg;
    updated_next = 1'b0;
    if (bus.accept) begin
      data_next    = bus.newData;
      valid_next   = 1'b1;
      updated_next = 1'b1;
    end
  end

  // Reset dominates accept on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg    <= RST_VAL;
      valid_reg   <= 1'b0;
      updated_reg <= 1'b0;
    end else begin
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      updated_reg <= updated_next;
    end
  end

  assign bus.data    = data_reg;
  assign bus.valid   = valid_reg;
  assign bus.updated = updated_reg;

`ifndef SYNTHESIS
  logic past_ok_reg;

  always_ff @(posedge clk) begin
    if (rst) past_ok_reg <= 1'b1;
  end

  a_updated_implies_valid : assert property (
    @(posedge clk) disable iff (rst) bus.updated |-> bus.valid
  );

  a_hold_when_idle : assert property (
    @(posedge clk) disable iff (rst)
      (past_ok_reg && !$past(rst) && !$past(bus.accept)) |-> $stable(bus.data)
  );

  a_accept_known : assert property (
    @(posedge clk) !rst |-> !$isunknown(bus.accept)
  );
`endif

endmodule : ac_out

// File: tb/tb_ac_out.sv
// Randomised self-checking bench for ac_out, compared against a cycle-level model of the
// load/hold/reset rules, preceded by a short directed sequence.
module tb_ac_out;

  logic clk;
  logic rst;

  ac_out_if #(.WIDTH(8)) bus ();

  ac_out #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_updated;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then check all outputs.
  task automatic step(input string tag, input logic r, input logic a, input logic [7:0] d);
    rst         = r;
    bus.accept  = a;
    bus.newData = d;
    @(posedge clk);
    if (r) begin
      m_data    = 8'h00;
      m_valid   = 1'b0;
      m_updated = 1'b0;
    end else if (a) begin
      m_data    = d;
      m_valid   = 1'b1;
      m_updated = 1'b1;
    end else begin
      m_updated = 1'b0;
    end
    #1;
    check_val({tag, ".data"},    32'(bus.data),    32'(m_data));
    check_val({tag, ".valid"},   32'(bus.valid),   32'(m_valid));
    check_val({tag, ".updated"}, 32'(bus.updated), 32'(m_updated));
    $display("[TB] %s rst=%0b acc=%0b nd=%02h -> data=%02h valid=%0b upd=%0b",
             tag, r, a, d, bus.data, bus.valid, bus.updated);
  endtask

  initial begin
    logic       r;
    logic       a;
    logic [7:0] d;

    tests_run    = 0;
    tests_failed = 0;
    m_data       = 8'h00;
    m_valid      = 1'b0;
    m_updated    = 1'b0;
    rst          = 1'b1;
    bus.accept   = 1'b1;
    bus.newData  = 8'hFF;

    // Reset holds off a simultaneous accept.
    step("rst0", 1'b1, 1'b1, 8'hFF);
    step("rst1", 1'b1, 1'b1, 8'hFF);

    step("load1", 1'b0, 1'b1, 8'h01);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 8'h02);

    step("load4", 1'b0, 1'b1, 8'h04);
    step("hold5", 1'b0, 1'b0, 8'h05);

    step("b2bA5", 1'b0, 1'b1, 8'hA5);
    step("b2b5A", 1'b0, 1'b1, 8'h5A);
    step("same5A", 1'b0, 1'b1, 8'h5A);

    step("midrst", 1'b1, 1'b1, 8'h33);
    step("resume", 1'b0, 1'b1, 8'hC3);

    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 19) == 0);
      a = ($urandom_range(0, 2) != 0);
      d = 8'($urandom);
      step("rand", r, a, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_ac_out
